math_task_exec: RTL and testbench

- Executes the field-arithmetic task stream emitted by the X25519 ladder sequencer: one task_t per task_valid pulse, acknowledged with a task_done pulse.
- Fetches operands from the shared field-element RAM, or reuses the previous result, for every task type.
- Performs mod-p add/sub locally and dispatches mul to an external modular multiplier.
- Writes the result back to RAM and keeps it in a result register for operand chaining.

---
 rtl/qnigma_math_pkg.sv | 41 ++++
 rtl/math_mod_addsub.sv | 30 +++
 rtl/math_task_exec.sv | 136 +++++++++++++
 tb/tb_math_task_exec.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qnigma_math_pkg.sv
// rtl/qnigma_math_pkg.sv - shared types and constants for the X25519 field-arithmetic datapath
package qnigma_math_pkg;

    localparam int FIELD_BITS = 255;
    localparam int PTR_BITS   = 8;

    // 2^255 - 19
    localparam logic [FIELD_BITS-1:0] P25519 = {{(FIELD_BITS-5){1'b1}}, 5'b01101};

    typedef logic [PTR_BITS-1:0] ptr_t;

    localparam ptr_t NULL      = '1;
    localparam ptr_t ADDR_ZERO = 8'h00;
    localparam ptr_t ADDR_ONE  = 8'h01;
    localparam ptr_t ADDR_X1   = 8'h02;
    localparam ptr_t ADDR_X2   = 8'h03;
    localparam ptr_t ADDR_Z2   = 8'h04;
    localparam ptr_t ADDR_X3   = 8'h05;
    localparam ptr_t ADDR_Z3   = 8'h06;
    localparam ptr_t ADDR_TMP0 = 8'h07;
    localparam ptr_t ADDR_TMP1 = 8'h08;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_CPY = 3'd3
    } op_t;

    typedef struct packed {
        op_t  op_typ;
        ptr_t rd_ptr_a;
        ptr_t rd_ptr_b;
        ptr_t wr_ptr;
        ptr_t cpy_src;
        ptr_t cpy_dst;
        logic opa_res;
        logic opb_res;
    } task_t;

endpackage

// File: rtl/math_mod_addsub.sv
// rtl/math_mod_addsub.sv - combinational mod-p add/sub for operands already below p
module math_mod_addsub #(
    parameter int                    FIELD_BITS = qnigma_math_pkg::FIELD_BITS,
    parameter logic [FIELD_BITS-1:0] P          = qnigma_math_pkg::P25519
) (
    input  logic [FIELD_BITS-1:0] a,
    input  logic [FIELD_BITS-1:0] b,
    input  logic                  sel_sub,
    output logic [FIELD_BITS-1:0] result
);

    logic [FIELD_BITS:0] p_ext;
    logic [FIELD_BITS:0] sum;
    logic [FIELD_BITS:0] diff;

    assign p_ext = {1'b0, P};
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};

    // One conditional correction suffices because both inputs are below p.
    always_comb begin
        result = '0;
        if (sel_sub) begin
            result = diff[FIELD_BITS] ? FIELD_BITS'(diff + p_ext) : diff[FIELD_BITS-1:0];
        end else begin
            result = (sum >= p_ext) ? FIELD_BITS'(sum - p_ext) : sum[FIELD_BITS-1:0];
        end
    end

endmodule

// File: rtl/math_task_exec.sv
// rtl/math_task_exec.sv - executes ladder field tasks: RAM fetch, add/sub/mul/cpy, write-back
module math_task_exec #(
    parameter int                    FIELD_BITS = qnigma_math_pkg::FIELD_BITS,
    parameter int                    PTR_BITS   = qnigma_math_pkg::PTR_BITS,
    parameter logic [FIELD_BITS-1:0] P          = qnigma_math_pkg::P25519
) (
    input  logic                   clk,
    input  logic                   rst,
    input  qnigma_math_pkg::task_t task_info,
    input  logic                   task_valid,
    output logic                   task_done,
    output logic [PTR_BITS-1:0]    ram_rd_addr,
    input  logic [FIELD_BITS-1:0]  ram_rd_data,
    output logic                   ram_wr_en,
    output logic [PTR_BITS-1:0]    ram_wr_addr,
    output logic [FIELD_BITS-1:0]  ram_wr_data,
    output logic                   mul_start,
    output logic [FIELD_BITS-1:0]  mul_a,
    output logic [FIELD_BITS-1:0]  mul_b,
    input  logic                   mul_done,
    input  logic [FIELD_BITS-1:0]  mul_res,
    output logic                   busy,
    output logic                   protocol_err
);
    import qnigma_math_pkg::*;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_A     = 3'd1;
    localparam logic [2:0] S_RD_B     = 3'd2;
    localparam logic [2:0] S_LATCH    = 3'd3;
    localparam logic [2:0] S_EXEC     = 3'd4;
    localparam logic [2:0] S_MUL_WAIT = 3'd5;
    localparam logic [2:0] S_WRITE    = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    logic [2:0]            state;
    task_t                 task_q;
    logic [FIELD_BITS-1:0] opa;
    logic [FIELD_BITS-1:0] opb;
    logic [FIELD_BITS-1:0] res_q;
    logic [FIELD_BITS-1:0] wdata;
    logic [FIELD_BITS-1:0] addsub_res;
    logic                  is_cpy;
    logic                  is_arith;
    ptr_t                  dst;

    assign is_cpy   = (task_q.op_typ == OP_CPY);
    assign is_arith = task_q.op_typ inside {OP_ADD, OP_SUB, OP_MUL};
    assign dst      = is_cpy ? task_q.cpy_dst : task_q.wr_ptr;

    assign busy        = (state != S_IDLE);
    assign task_done   = (state == S_DONE);
    assign mul_start   = (state == S_EXEC) && (task_q.op_typ == OP_MUL);
    assign mul_a       = opa;
    assign mul_b       = opb;
    assign ram_wr_en   = (state == S_WRITE) && (is_arith || is_cpy) && (dst != NULL);
    assign ram_wr_addr = ram_wr_en ? dst : '0;
    assign ram_wr_data = ram_wr_en ? wdata : '0;

    always_comb begin
        ram_rd_addr = '0;
        if (state == S_RD_A) begin
            ram_rd_addr = is_cpy ? task_q.cpy_src : task_q.rd_ptr_a;
        end else if (state == S_RD_B && !is_cpy) begin
            ram_rd_addr = task_q.rd_ptr_b;
        end
    end

    math_mod_addsub #(
        .FIELD_BITS (FIELD_BITS),
        .P          (P)
    ) u_addsub (
        .a       (opa),
        .b       (opb),
        .sel_sub (task_q.op_typ == OP_SUB),
        .result  (addsub_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            task_q       <= '0;
            opa          <= '0;
            opb          <= '0;
            res_q        <= '0;
            wdata        <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (task_valid && busy) begin
                protocol_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (task_valid) begin
                        task_q <= task_info;
                        state  <= S_RD_A;
                    end
                end
                S_RD_A: state <= S_RD_B;
                S_RD_B: begin
                    // res_q still holds the previous task's result here, so chaining sees the old value.
                    opa   <= task_q.opa_res ? res_q : ram_rd_data;
                    wdata <= ram_rd_data;
                    state <= is_arith ? S_LATCH : S_WRITE;
                end
                S_LATCH: begin
                    opb   <= task_q.opb_res ? res_q : ram_rd_data;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (task_q.op_typ == OP_MUL) begin
                        state <= S_MUL_WAIT;
                    end else begin
                        wdata <= addsub_res;
                        state <= S_WRITE;
                    end
                end
                S_MUL_WAIT: begin
                    if (mul_done) begin
                        wdata <= mul_res;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (is_arith) begin
                        res_q <= wdata;
                    end
                    state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_math_task_exec.sv
// tb/tb_math_task_exec.sv - self-checking bench for math_task_exec with RAM and multiplier models
module tb_math_task_exec;
    import qnigma_math_pkg::*;

    typedef logic [FIELD_BITS-1:0] fe_t;

    typedef struct {
        task_t t;
        bit    wr;
        ptr_t  addr;
        fe_t   data;
        int    lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    task_t       task_info;
    logic        task_valid;
    logic        task_done;
    ptr_t        ram_rd_addr;
    fe_t         ram_rd_data;
    logic        ram_wr_en;
    ptr_t        ram_wr_addr;
    fe_t         ram_wr_data;
    logic        mul_start;
    fe_t         mul_a;
    fe_t         mul_b;
    logic        mul_done;
    fe_t         mul_res;
    logic        busy;
    logic        protocol_err;

    always #5 clk = ~clk;

    math_task_exec dut (
        .clk          (clk),
        .rst          (rst),
        .task_info    (task_info),
        .task_valid   (task_valid),
        .task_done    (task_done),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_data  (ram_rd_data),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_data  (ram_wr_data),
        .mul_start    (mul_start),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_done     (mul_done),
        .mul_res      (mul_res),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int mul_lat = 4;

    fe_t  ref_mem [256];
    fe_t  ref_res;
    vec_t vt [10];

    // Field-element RAM: one-cycle read latency, plus a bench-side preload port.
    fe_t  mem [256];
    logic pl_en;
    ptr_t pl_addr;
    fe_t  pl_data;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_wr_en) begin
            mem[ram_wr_addr] <= ram_wr_data;
        end
        ram_rd_data <= mem[ram_rd_addr];
    end

    function automatic fe_t mod_add(input fe_t a, input fe_t b);
        logic [FIELD_BITS:0] s;
        s = ({1'b0, a} + {1'b0, b}) % {1'b0, P25519};
        return s[FIELD_BITS-1:0];
    endfunction

    function automatic fe_t mod_sub(input fe_t a, input fe_t b);
        logic [FIELD_BITS:0] s;
        s = ({1'b0, a} + {1'b0, P25519} - {1'b0, b}) % {1'b0, P25519};
        return s[FIELD_BITS-1:0];
    endfunction

    function automatic fe_t mod_mul(input fe_t a, input fe_t b);
        logic [2*FIELD_BITS-1:0] pr;
        pr = ({{FIELD_BITS{1'b0}}, a} * {{FIELD_BITS{1'b0}}, b}) % {{FIELD_BITS{1'b0}}, P25519};
        return pr[FIELD_BITS-1:0];
    endfunction

    function automatic fe_t rand_fe();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        v[255] = 1'b0;
        if (v[254:0] >= P25519) v = v - {1'b0, P25519};
        return v[254:0];
    endfunction

    // Multiplier stub: answers mul_lat cycles after the request with the true product mod p.
    initial begin : mul_stub
        fe_t sa;
        fe_t sb;
        mul_done = 1'b0;
        mul_res  = '0;
        forever begin
            @(negedge clk);
            if (mul_start) begin
                sa = mul_a;
                sb = mul_b;
                repeat (mul_lat) @(negedge clk);
                mul_done = 1'b1;
                mul_res  = mod_mul(sa, sb);
                @(negedge clk);
                mul_done = 1'b0;
                mul_res  = '0;
            end
        end
    end

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic task_t mk(input op_t op, input ptr_t ra, input ptr_t rb, input ptr_t wr,
                                 input ptr_t src, input ptr_t dst, input bit ar, input bit br);
        task_t t;
        t.op_typ   = op;
        t.rd_ptr_a = ra;
        t.rd_ptr_b = rb;
        t.wr_ptr   = wr;
        t.cpy_src  = src;
        t.cpy_dst  = dst;
        t.opa_res  = ar;
        t.opb_res  = br;
        return t;
    endfunction

    // Reference model: what one task should do to RAM and the result register.
    function automatic void predict(input task_t t, output bit wr, output ptr_t addr, output fe_t r,
                                    output bit upd, output int lat, output fe_t a, output fe_t b);
        a    = t.opa_res ? ref_res : ref_mem[t.rd_ptr_a];
        b    = t.opb_res ? ref_res : ref_mem[t.rd_ptr_b];
        upd  = 1'b1;
        addr = t.wr_ptr;
        case (t.op_typ)
            OP_ADD:  begin r = mod_add(a, b); lat = 6; end
            OP_SUB:  begin r = mod_sub(a, b); lat = 6; end
            OP_MUL:  begin r = mod_mul(a, b); lat = mul_lat + 6; end
            OP_CPY:  begin r = ref_mem[t.cpy_src]; addr = t.cpy_dst; upd = 1'b0; lat = 4; end
            default: begin r = '0; addr = NULL; upd = 1'b0; lat = 4; end
        endcase
        wr = (addr != NULL);
    endfunction

    function automatic void commit(input bit wr, input ptr_t addr, input fe_t r, input bit upd);
        if (wr) ref_mem[addr] = r;
        if (upd) ref_res = r;
    endfunction

    task automatic run_task(input string nm, input task_t t, input bit ewr, input ptr_t eaddr,
                            input fe_t edata, input int elat, input int intrude,
                            input fe_t ema, input fe_t emb);
        int   done_cyc = -1;
        int   nwr = 0;
        bit   busy_bad = 1'b0;
        bit   saw_mul = 1'b0;
        ptr_t waddr = '0;
        fe_t  wdat = '0;
        fe_t  ma = '0;
        fe_t  mb = '0;
        @(negedge clk);
        task_info  = t;
        task_valid = 1'b1;
        for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            task_valid = (cyc == intrude);
            if (cyc == intrude) task_info = mk(OP_ADD, ADDR_ONE, ADDR_ONE, ADDR_ONE, NULL, NULL, 1'b0, 1'b0);
            if (!busy) busy_bad = 1'b1;
            if (ram_wr_en) begin
                nwr++;
                waddr = ram_wr_addr;
                wdat  = ram_wr_data;
            end
            if (mul_start) begin
                saw_mul = 1'b1;
                ma = mul_a;
                mb = mul_b;
            end
            if (task_done) done_cyc = cyc;
        end
        task_valid = 1'b0;
        check({nm, "_latency"}, done_cyc, elat);
        check({nm, "_nwrites"}, nwr, {31'b0, ewr});
        check({nm, "_busy_during"}, busy_bad, 0);
        if (ewr) begin
            check({nm, "_wr_addr"}, waddr, eaddr);
            check({nm, "_wr_data"}, wdat, edata);
        end
        if (t.op_typ == OP_MUL) begin
            check({nm, "_mul_start"}, saw_mul, 1);
            check({nm, "_mul_a"}, ma, ema);
            check({nm, "_mul_b"}, mb, emb);
        end
        @(negedge clk);
        check({nm, "_busy_after"}, busy, 0);
    endtask

    task automatic run_vec(input string nm, input task_t t, input bit ewr, input ptr_t eaddr,
                           input fe_t edata, input int elat, input int intrude);
        bit   wr;
        bit   upd;
        ptr_t addr;
        fe_t  r;
        fe_t  a;
        fe_t  b;
        int   lat;
        predict(t, wr, addr, r, upd, lat, a, b);
        run_task(nm, t, ewr, eaddr, edata, elat, intrude, a, b);
        commit(wr, addr, r, upd);
    endtask

    task automatic run_model(input string nm, input task_t t);
        bit   wr;
        bit   upd;
        ptr_t addr;
        fe_t  r;
        fe_t  a;
        fe_t  b;
        int   lat;
        predict(t, wr, addr, r, upd, lat, a, b);
        run_task(nm, t, wr, addr, r, lat, 0, a, b);
        commit(wr, addr, r, upd);
    endtask

    task automatic preload();
        fe_t v;
        for (int i = 0; i < 256; i++) begin
            case (i)
                0:       v = '0;
                1:       v = fe_t'(1);
                8'h40:   v = P25519 - fe_t'(1);
                8'h41:   v = fe_t'(5);
                8'h42:   v = fe_t'(3);
                default: v = rand_fe();
            endcase
            @(negedge clk);
            pl_en      = 1'b1;
            pl_addr    = ptr_t'(i);
            pl_data    = v;
            ref_mem[i] = v;
        end
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    initial begin : main
        task_t t;
        fe_t   xy;
        int    k;
        int    n_done;
        int    n_wr;
        int    n_late;
        rst        = 1'b1;
        task_valid = 1'b0;
        task_info  = '0;
        pl_en      = 1'b0;
        pl_addr    = '0;
        pl_data    = '0;
        ref_res    = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_task_done", task_done, 0);
        check("rst_wr_en", ram_wr_en, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_rd_addr", ram_rd_addr, 0);
        check("rst_protocol_err", protocol_err, 0);
        rst = 1'b0;
        preload();

        vt[0] = '{mk(OP_ADD, 8'h40, 8'h41, 8'h50, NULL, NULL, 1'b0, 1'b0), 1'b1, 8'h50, fe_t'(4), 6};
        vt[1] = '{mk(OP_SUB, 8'h42, 8'h41, 8'h51, NULL, NULL, 1'b0, 1'b0), 1'b1, 8'h51, P25519 - fe_t'(2), 6};
        vt[2] = '{mk(OP_ADD, 8'h00, 8'h41, 8'h52, NULL, NULL, 1'b1, 1'b0), 1'b1, 8'h52, fe_t'(3), 6};
        vt[3] = '{mk(OP_CPY, 8'h40, 8'h41, 8'h59, ADDR_ONE, ADDR_X2, 1'b0, 1'b0), 1'b1, ADDR_X2, fe_t'(1), 4};
        vt[4] = '{mk(OP_CPY, 8'h40, 8'h41, 8'h59, ADDR_ONE, NULL, 1'b0, 1'b0), 1'b0, NULL, '0, 4};
        vt[5] = '{mk(op_t'(3'd6), 8'h40, 8'h41, 8'h58, ADDR_ONE, 8'h58, 1'b0, 1'b0), 1'b0, NULL, '0, 4};
        vt[6] = '{mk(OP_ADD, 8'h00, ADDR_ZERO, 8'h53, NULL, NULL, 1'b1, 1'b0), 1'b1, 8'h53, fe_t'(3), 6};
        vt[7] = '{mk(OP_SUB, 8'h41, 8'h41, 8'h54, NULL, NULL, 1'b0, 1'b0), 1'b1, 8'h54, '0, 6};
        vt[8] = '{mk(OP_ADD, 8'h40, 8'h42, NULL, NULL, NULL, 1'b0, 1'b0), 1'b0, NULL, '0, 6};
        vt[9] = '{mk(OP_ADD, 8'h00, 8'h00, 8'h55, NULL, NULL, 1'b1, 1'b1), 1'b1, 8'h55, fe_t'(4), 6};
        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), vt[i].t, vt[i].wr, vt[i].addr, vt[i].data, vt[i].lat, 0);
        end

        // Chained squaring through the result register with a slow multiplier.
        mul_lat = 10;
        xy = mod_mul(ref_mem[8'h60], ref_mem[8'h61]);
        run_vec("mul_xy", mk(OP_MUL, 8'h60, 8'h61, 8'h62, NULL, NULL, 1'b0, 1'b0), 1'b1, 8'h62, xy, 16, 0);
        run_vec("mul_sq", mk(OP_MUL, 8'h00, 8'h00, NULL, NULL, NULL, 1'b1, 1'b1), 1'b0, NULL, '0, 16, 0);
        run_vec("sq_readback", mk(OP_ADD, 8'h00, ADDR_ZERO, 8'h63, NULL, NULL, 1'b1, 1'b0),
                1'b1, 8'h63, mod_mul(xy, xy), 6, 0);

        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, 9);
            mul_lat = $urandom_range(1, 6);
            t = mk(k < 3 ? OP_ADD : k < 6 ? OP_SUB : k < 8 ? OP_MUL : k < 9 ? OP_CPY : op_t'(3'd5),
                   ptr_t'($urandom_range(0, 191)), ptr_t'($urandom_range(0, 191)),
                   ($urandom_range(0, 5) == 0) ? NULL : ptr_t'($urandom_range(128, 191)),
                   ptr_t'($urandom_range(0, 191)),
                   ($urandom_range(0, 5) == 0) ? NULL : ptr_t'($urandom_range(128, 191)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_model($sformatf("rand%0d", i), t);
        end

        check("perr_before", protocol_err, 0);
        run_vec("proto_add", mk(OP_ADD, 8'h40, 8'h41, 8'h57, NULL, NULL, 1'b0, 1'b0), 1'b1, 8'h57, fe_t'(4), 6, 2);
        check("perr_after", protocol_err, 1);

        // Reset while waiting on the multiplier; the late mul_done must be ignored.
        mul_lat = 10;
        @(negedge clk);
        task_info  = mk(OP_MUL, 8'h60, 8'h61, 8'h64, NULL, NULL, 1'b0, 1'b0);
        task_valid = 1'b1;
        @(negedge clk);
        task_valid = 1'b0;
        for (int c = 0; c < 20 && !mul_start; c++) @(negedge clk);
        check("rmul_start_seen", mul_start, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rmul_busy", busy, 0);
        check("rmul_wr_en", ram_wr_en, 0);
        check("rmul_wr_data", ram_wr_data, 0);
        check("rmul_mul_a", mul_a, 0);
        check("rmul_mul_b", mul_b, 0);
        check("rmul_perr", protocol_err, 0);
        @(negedge clk);
        rst = 1'b0;
        ref_res = '0;
        n_done = 0;
        n_wr = 0;
        n_late = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (task_done) n_done++;
            if (ram_wr_en) n_wr++;
            if (mul_done) n_late++;
        end
        check("rmul_no_done", n_done, 0);
        check("rmul_no_write", n_wr, 0);
        check("rmul_late_mul_done", n_late, 1);
        check("rmul_idle", busy, 0);
        run_vec("post_rst_add", mk(OP_ADD, 8'h00, 8'h41, 8'h56, NULL, NULL, 1'b1, 1'b0), 1'b1, 8'h56, fe_t'(5), 6, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
